wfg_wb_initiator: RTL and testbench

WFG_WB_INITIATOR -- requirements
Module: wfg_wb_initiator

---
 rtl/wfg_wb_initiator_pkg.sv | 20 ++
 rtl/wfg_wb_initiator.sv | 129 ++++++++++++
 tb/tb_wfg_wb_initiator.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wfg_wb_initiator_pkg.sv
// ============================================================================
// Module  : wfg_wb_initiator_pkg
// Brief   : Shared types and constants for the Wishbone classic initiator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wfg_wb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_t;

  localparam int c_cnt_w = 8;

endpackage : wfg_wb_initiator_pkg

`default_nettype wire

// File: rtl/wfg_wb_initiator.sv
// ============================================================================
// Module  : wfg_wb_initiator
// Brief   : Single-outstanding Wishbone classic master with ack timeout abort.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wfg_wb_initiator
  import wfg_wb_initiator_pkg::*;
#(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // command channel
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [BUSW-1:0]   cmd_adr_i,
  input  logic [BUSW-1:0]   cmd_dat_i,
  // response channel
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUSW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  // Wishbone master
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  input  logic              wbm_ack_i,
  input  logic [BUSW-1:0]   wbm_dat_i
);

  // Count value seen on the last permitted BUS cycle.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  wb_state_t          r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_cmd_ready;
  logic               r_cyc;
  logic               r_we;
  logic [BUSW-1:0]    r_adr;
  logic [BUSW-1:0]    r_dat;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [BUSW-1:0]    r_rsp_dat;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Ready rises one cycle after reset release, then tracks IDLE.
          r_cmd_ready <= 1'b1;
          if (cmd_valid_i && r_cmd_ready) begin
            r_we        <= cmd_we_i;
            r_adr       <= cmd_adr_i;
            r_dat       <= cmd_dat_i;
            r_cnt       <= '0;
            r_cyc       <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= BUS;
          end
        end

        BUS: begin
          if (wbm_ack_i) begin
            r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_cyc       <= 1'b0;
            r_state     <= RESP;
          end else if (r_cnt == c_cnt_last) begin
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_cyc       <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign wbm_sel_o   = '1;

endmodule : wfg_wb_initiator

`default_nettype wire

// File: tb/tb_wfg_wb_initiator.sv
// ============================================================================
// Module  : tb_wfg_wb_initiator
// Brief   : Directed vector bench for the Wishbone classic initiator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wfg_wb_initiator;

  localparam int BUSW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [BUSW-1:0] cmd_adr_i, cmd_dat_i;
  logic            rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [BUSW-1:0] rsp_dat_o;
  logic            wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [BUSW-1:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [BUSW/8-1:0] wbm_sel_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wfg_wb_initiator #(.BUSW(BUSW), .TIMEOUT(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          ack_at;   // BUS cycle on which the slave acks; 0 = never
    logic [31:0] rdata;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int    n;
    logic  bad;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, ".cmd_ready_idle"}, {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = v.we;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    @(negedge clk);
    // Scramble command inputs so the bus must be driven from registered copies.
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~v.we;
    cmd_adr_i   = 32'hFFFF_FFFF;
    cmd_dat_i   = 32'hFFFF_FFFF;
    n   = 0;
    bad = 1'b0;
    while (wbm_cyc_o === 1'b1 && n < 300) begin
      n++;
      if (wbm_stb_o !== 1'b1 || wbm_we_o !== v.we || wbm_adr_o !== v.adr ||
          wbm_dat_o !== v.dat || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b0)
        bad = 1'b1;
      if (n == v.ack_at) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = v.rdata;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h5A5A_0000 + 32'(n);
      end
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    chk({tag, ".bus_cycles"}, 32'(n), 32'(v.exp_cyc));
    chk({tag, ".bus_stable"}, {31'd0, bad}, 32'd0);
    chk({tag, ".rsp_valid"},  {31'd0, rsp_valid_o}, 32'd1);
    chk({tag, ".rsp_err"},    {31'd0, rsp_err_o}, {31'd0, v.exp_err});
    chk({tag, ".rsp_dat"},    rsp_dat_o, v.exp_dat);
    chk({tag, ".stb_low"},    {31'd0, wbm_stb_o}, 32'd0);
    chk({tag, ".cmd_ready_resp"}, {31'd0, cmd_ready_o}, 32'd0);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk({tag, ".rsp_valid_done"}, {31'd0, rsp_valid_o}, 32'd0);
    chk({tag, ".cmd_ready_back"}, {31'd0, cmd_ready_o}, 32'd1);
  endtask

  initial begin
    logic bad;
    // {we, adr, dat, ack_at, rdata, exp_cyc, exp_err, exp_dat}
    vecs[0] = '{1'b1, 32'h0000_0010, 32'h0000_0001, 3,  32'hAAAA_5555, 3,  1'b0, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 1,  32'hDEAD_BEEF, 1,  1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 0,  32'h0000_0000, 16, 1'b1, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0044, 32'h0000_0000, 16, 32'h1234_5678, 16, 1'b0, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'h0000_0048, 32'hCAFE_F00D, 17, 32'h0BAD_0BAD, 16, 1'b1, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'h0000_004C, 32'h0000_0000, 15, 32'h0F0F_0F0F, 15, 1'b0, 32'h0F0F_0F0F};

    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0;
    rsp_ready_i = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    chk("rst.cyc",       {31'd0, wbm_cyc_o},   32'd0);
    chk("rst.rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst.adr",       wbm_adr_o,            32'd0);
    chk("rst.rsp_dat",   rsp_dat_o,            32'd0);
    chk("rst.sel",       {28'd0, wbm_sel_o},   32'h0000_000F);
    rst = 1'b0;
    @(negedge clk);
    chk("rel.cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // Response back-pressure with a queued command and stray acks
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h0000_0080; cmd_dat_i = '0;
    @(negedge clk);
    cmd_we_i = 1'b1; cmd_adr_i = 32'h0000_0084; cmd_dat_i = 32'h0000_0077;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h1111_2222;
    @(negedge clk);
    wbm_dat_i = 32'h9999_9999;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h1111_2222 || rsp_err_o !== 1'b0 ||
          cmd_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0)
        bad = 1'b1;
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    chk("hold.stable", {31'd0, bad}, 32'd0);
    chk("hold.rsp_dat", rsp_dat_o, 32'h1111_2222);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("hold.rsp_valid_done", {31'd0, rsp_valid_o}, 32'd0);
    chk("hold.cyc_not_yet",    {31'd0, wbm_cyc_o},   32'd0);
    chk("hold.cmd_ready",      {31'd0, cmd_ready_o}, 32'd1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("queued.cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("queued.adr", wbm_adr_o, 32'h0000_0084);
    chk("queued.dat", wbm_dat_o, 32'h0000_0077);
    chk("queued.we",  {31'd0, wbm_we_o}, 32'd1);
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("queued.rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("queued.rsp_dat",   rsp_dat_o, 32'h0000_0000);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;

    // Asynchronous reset in the middle of a BUS phase
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h0000_0090; cmd_dat_i = 32'h0000_00AB;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid.cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid.cyc",       {31'd0, wbm_cyc_o},   32'd0);
    chk("mid.stb",       {31'd0, wbm_stb_o},   32'd0);
    chk("mid.we",        {31'd0, wbm_we_o},    32'd0);
    chk("mid.adr",       wbm_adr_o,            32'd0);
    chk("mid.cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0 || wbm_cyc_o !== 1'b0) bad = 1'b1;
    end
    wbm_ack_i = 1'b0;
    chk("mid.no_rsp", {31'd0, bad}, 32'd0);
    run_txn(vecs[1], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wfg_wb_initiator

`default_nettype wire
